// File: rtl/seg7_debug_display.sv
// Four-digit seven-segment debug viewer for the CPU core on the Basys-3.
// A debounced button cycles through five pages of core debug state.
module seg7_debug_display #(
    parameter int unsigned REFRESH_DIV     = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  state_dbg,
    input  logic [7:0]  pc_dbg,
    input  logic [15:0] ir_dbg,
    input  logic [15:0] alu_out_dbg,
    input  logic [15:0] rs_val_dbg,
    input  logic [15:0] rt_val_dbg,
    input  logic        btn_page,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [2:0]  page_dbg
);

    localparam int unsigned RCW = $clog2(REFRESH_DIV);
    localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [RCW-1:0] REFRESH_LAST  = RCW'(REFRESH_DIV - 1);
    localparam logic [DCW-1:0] DEBOUNCE_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        PAGE_IR       = 3'd0,
        PAGE_PC_STATE = 3'd1,
        PAGE_ALU      = 3'd2,
        PAGE_RS       = 3'd3,
        PAGE_RT       = 3'd4
    } page_t;

    logic [RCW-1:0] refresh_cnt;
    logic [1:0]     idx;
    logic [1:0]     idx_next;
    logic           tick;
    logic [15:0]    snapshot;
    logic [15:0]    live;
    logic [15:0]    digit_src;
    logic [3:0]     nibble;
    page_t          page;
    page_t          next_page;
    page_t          frame_page;
    page_t          disp_page;
    logic           blank;
    logic [3:0]     an_next;
    logic           dp_next;

    logic           sync_ff1;
    logic           sync_ff2;
    logic           stable;
    logic [DCW-1:0] db_cnt;
    logic           page_step;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        live = ir_dbg;
        unique case (page)
            PAGE_IR:       live = ir_dbg;
            PAGE_PC_STATE: live = {pc_dbg, 4'h0, 1'b0, state_dbg};
            PAGE_ALU:      live = alu_out_dbg;
            PAGE_RS:       live = rs_val_dbg;
            PAGE_RT:       live = rt_val_dbg;
            default:       live = ir_dbg;
        endcase
    end

    always_comb begin
        next_page = PAGE_IR;
        if (page != PAGE_RT) begin
            next_page = page_t'(page + 3'd1);
        end
    end

    always_comb begin
        tick     = (refresh_cnt == REFRESH_LAST);
        idx_next = idx - 2'd1;
        // The leading digit of a frame reads the live value, since the
        // snapshot is only being captured on that same edge.
        digit_src = (idx_next == 2'd3) ? live : snapshot;
        disp_page = (idx_next == 2'd3) ? page : frame_page;
        nibble    = 4'h0;
        unique case (idx_next)
            2'd3:    nibble = digit_src[15:12];
            2'd2:    nibble = digit_src[11:8];
            2'd1:    nibble = digit_src[7:4];
            default: nibble = digit_src[3:0];
        endcase
        blank   = (disp_page == PAGE_PC_STATE) && (idx_next == 2'd1);
        dp_next = !((disp_page == PAGE_PC_STATE) && (idx_next == 2'd0));
        an_next = ~(4'b0001 << idx_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            idx         <= 2'd0;
            snapshot    <= '0;
            frame_page  <= PAGE_IR;
            an          <= '1;
            seg         <= '1;
            dp          <= 1'b1;
        end else if (tick) begin
            refresh_cnt <= '0;
            idx         <= idx_next;
            if (idx_next == 2'd3) begin
                snapshot   <= live;
                frame_page <= page;
            end
            an  <= an_next;
            seg <= blank ? 7'b1111111 : hex7(nibble);
            dp  <= dp_next;
        end else begin
            refresh_cnt <= refresh_cnt + RCW'(1);
        end
    end

    assign page_step = (sync_ff2 != stable) && (db_cnt == DEBOUNCE_LAST) && sync_ff2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
            stable   <= 1'b0;
            db_cnt   <= '0;
            page     <= PAGE_IR;
        end else begin
            sync_ff1 <= btn_page;
            sync_ff2 <= sync_ff1;
            if (sync_ff2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DEBOUNCE_LAST) begin
                stable <= sync_ff2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DCW'(1);
            end
            // Advance on the accepted rising edge itself, saving a cycle of latency.
            if (page_step) begin
                page <= next_page;
            end
        end
    end

    assign page_dbg = page;

endmodule

// File: tb/tb_seg7_debug_display.sv
// Scoreboard bench for seg7_debug_display with a short refresh and debounce.
module tb_seg7_debug_display;

    localparam int DIV = 4;
    localparam int DB  = 8;
    localparam logic [6:0] HEX_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  state_dbg = 3'd0;
    logic [7:0]  pc_dbg = 8'h00;
    logic [15:0] ir_dbg = 16'h1A2F;
    logic [15:0] alu_out_dbg = 16'h0000;
    logic [15:0] rs_val_dbg = 16'h0C57;
    logic [15:0] rt_val_dbg = 16'h9E8B;
    logic        btn_page = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [2:0]  page_dbg;

    int checks = 0;
    int failures = 0;
    int exp_page = 0;
    logic [11:0] exp_q [$];
    int page_q [$];

    seg7_debug_display #(.REFRESH_DIV(DIV), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .state_dbg(state_dbg), .pc_dbg(pc_dbg),
        .ir_dbg(ir_dbg), .alu_out_dbg(alu_out_dbg), .rs_val_dbg(rs_val_dbg),
        .rt_val_dbg(rt_val_dbg), .btn_page(btn_page), .seg(seg), .dp(dp),
        .an(an), .page_dbg(page_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] live_val(input int p);
        case (p)
            0: return ir_dbg;
            1: return {pc_dbg, 4'h0, 1'b0, state_dbg};
            2: return alu_out_dbg;
            3: return rs_val_dbg;
            default: return rt_val_dbg;
        endcase
    endfunction

    function automatic void push_frame(input int p, input logic [15:0] v);
        logic [3:0] a;
        logic [6:0] s;
        logic       d_p;
        for (int d = 3; d >= 0; d--) begin
            a   = 4'b0001 << d;
            a   = ~a;
            s   = (p == 1 && d == 1) ? 7'b1111111 : HEX_TBL[v[d*4 +: 4]];
            d_p = !(p == 1 && d == 0);
            for (int k = 0; k < DIV; k++) exp_q.push_back({a, s, d_p});
        end
    endfunction

    task automatic wait_frame(output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        prev = an;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an == 4'b0111 && prev != 4'b0111) begin
                ok = 1'b1;
                break;
            end
            prev = an;
        end
    endtask

    task automatic press(output int lat);
        logic [2:0] start_pg;
        start_pg = page_dbg;
        lat = -1;
        btn_page = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (lat < 0 && page_dbg != start_pg) lat = i;
        end
        btn_page = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [11:0] e;
        repeat (3) @(negedge clk);
        checks++;
        if ({an, seg, dp, page_dbg} !== {4'b1111, 7'b1111111, 1'b1, 3'd0}) begin
            failures++;
            $display("FAIL reset_values an=%b seg=%b dp=%b page=%0d exp an=1111 seg=1111111 dp=1 page=0",
                     an, seg, dp, page_dbg);
        end
        reset = 1'b0;
        for (int i = 0; i < DIV; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({an, seg} !== {4'b1111, 7'b1111111}) begin
                failures++;
                $display("FAIL pre_tick[%0d] an=%b seg=%b exp an=1111 seg=1111111", i, an, seg);
            end
        end
        @(negedge clk);
        push_frame(0, 16'h1A2F);
        for (int i = 0; i < 4*DIV; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                failures++;
                $display("FAIL first_frame[%0d] an/seg/dp=%b/%b/%b exp %b/%b/%b",
                         i, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_debounce;
        int lat;
        btn_page = 1'b1;
        repeat (5) @(negedge clk);
        btn_page = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (page_dbg !== 3'd0) begin
            failures++;
            $display("FAIL glitch_rejected page=%0d exp 0", page_dbg);
        end
        lat = -1;
        btn_page = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (lat < 0 && page_dbg == 3'd1) lat = i;
        end
        btn_page = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (lat < 9 || lat > 11) begin
            failures++;
            $display("FAIL press_latency latency=%0d exp 9..11", lat);
        end
        checks++;
        if (page_dbg !== 3'd1) begin
            failures++;
            $display("FAIL single_increment page=%0d exp 1", page_dbg);
        end
        exp_page = 1;
    endtask

    task automatic test_page1;
        bit ok;
        logic [11:0] e;
        pc_dbg = 8'h3C;
        state_dbg = 3'd5;
        wait_frame(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL page1_frame_wait got timeout exp frame start");
        end
        push_frame(1, {8'h3C, 4'h0, 1'b0, 3'd5});
        for (int i = 0; i < 4*DIV; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                failures++;
                $display("FAIL page1_frame[%0d] an/seg/dp=%b/%b/%b exp %b/%b/%b",
                         i, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_tearing;
        bit ok;
        int lat;
        logic [11:0] e;
        press(lat);
        exp_page = 2;
        checks++;
        if (page_dbg !== 3'd2) begin
            failures++;
            $display("FAIL tearing_page page=%0d exp 2", page_dbg);
        end
        alu_out_dbg = 16'h1234;
        wait_frame(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL tearing_frame_wait got timeout exp frame start");
        end
        push_frame(2, 16'h1234);
        push_frame(2, 16'hABCD);
        for (int i = 0; i < 8*DIV; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                failures++;
                $display("FAIL tearing_frame[%0d] an/seg/dp=%b/%b/%b exp %b/%b/%b",
                         i, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
            if (i == DIV + 1) alu_out_dbg = 16'hABCD;
        end
    endtask

    task automatic test_wrap;
        bit ok;
        int lat;
        int p;
        logic [11:0] e;
        for (int k = 0; k < 5; k++) begin
            press(lat);
            exp_page = (exp_page + 1) % 5;
            page_q.push_back(exp_page);
            p = page_q.pop_front();
            checks++;
            if (page_dbg !== 3'(p)) begin
                failures++;
                $display("FAIL wrap_page[%0d] page=%0d exp %0d", k, page_dbg, p);
            end
            wait_frame(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL wrap_frame_wait[%0d] got timeout exp frame start", k);
            end
            push_frame(p, live_val(p));
            for (int i = 0; i < 4*DIV; i++) begin
                if (i > 0) @(negedge clk);
                e = exp_q.pop_front();
                checks++;
                if ({an, seg, dp} !== e) begin
                    failures++;
                    $display("FAIL wrap_frame[%0d][%0d] an/seg/dp=%b/%b/%b exp %b/%b/%b",
                             k, i, an, seg, dp, e[11:8], e[7:1], e[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int lat;
        logic [11:0] e;
        press(lat);
        exp_page = 3;
        checks++;
        if (page_dbg !== 3'd3) begin
            failures++;
            $display("FAIL reset_mid_page page=%0d exp 3", page_dbg);
        end
        wait_frame(ok);
        repeat (6) @(negedge clk);
        btn_page = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        btn_page = 1'b0;
        @(negedge clk);
        exp_page = 0;
        checks++;
        if ({an, seg, dp, page_dbg} !== {4'b1111, 7'b1111111, 1'b1, 3'd0}) begin
            failures++;
            $display("FAIL reset_mid an=%b seg=%b dp=%b page=%0d exp an=1111 seg=1111111 dp=1 page=0",
                     an, seg, dp, page_dbg);
        end
        reset = 1'b0;
        for (int i = 0; i < DIV; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (an !== 4'b1111) begin
                failures++;
                $display("FAIL reset_mid_pre_tick[%0d] an=%b exp 1111", i, an);
            end
        end
        @(negedge clk);
        push_frame(0, ir_dbg);
        for (int i = 0; i < 4*DIV; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                failures++;
                $display("FAIL reset_mid_frame[%0d] an/seg/dp=%b/%b/%b exp %b/%b/%b",
                         i, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (page_dbg !== 3'(exp_page)) begin
            failures++;
            $display("FAIL reset_mid_no_advance page=%0d exp %0d", page_dbg, exp_page);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_page1();
        test_tearing();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
